// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Signal bundle between the pipeline and the branch predictor.
//                Carries the IF-stage lookup, the ID-stage branch candidate,
//                the forwarding operand sources and the resolution results.
//                When BP_STATS_EN is defined, the bundle also carries the
//                16-bit branch_count and miss_count statistics outputs.
//  Ports       : master - pipeline side (drives PCs, opcode, operands)
//                slave  - predictor side (drives prediction and resolution)
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
   parameter int DATA_W = 32
);
   // IF stage
   logic [DATA_W-1:0] if_pc;
   logic              pred_taken;
   // ID stage
   logic              id_valid;
   logic              id_stall;
   logic [DATA_W-1:0] id_pc;
   logic [5:0]        id_op;
   logic              id_pred;
   // Forwarding
   logic [1:0]        fa;
   logic [1:0]        fb;
   logic [DATA_W-1:0] reg_out1;
   logic [DATA_W-1:0] reg_out2;
   logic [DATA_W-1:0] memwb_value;
   logic [DATA_W-1:0] exmem_aluout;
   // Resolution
   logic              take_branch;
   logic              mispredict;
`ifdef BP_STATS_EN
   logic [15:0]       branch_count;
   logic [15:0]       miss_count;
`endif

   modport master (
`ifdef BP_STATS_EN
      input  branch_count,
      input  miss_count,
`endif
      output if_pc,
      input  pred_taken,
      output id_valid,
      output id_stall,
      output id_pc,
      output id_op,
      output id_pred,
      output fa,
      output fb,
      output reg_out1,
      output reg_out2,
      output memwb_value,
      output exmem_aluout,
      input  take_branch,
      input  mispredict
   );

   modport slave (
`ifdef BP_STATS_EN
      output branch_count,
      output miss_count,
`endif
      input  if_pc,
      output pred_taken,
      input  id_valid,
      input  id_stall,
      input  id_pc,
      input  id_op,
      input  id_pred,
      input  fa,
      input  fb,
      input  reg_out1,
      input  reg_out2,
      input  memwb_value,
      input  exmem_aluout,
      output take_branch,
      output mispredict
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Bimodal branch predictor with ID-stage resolution of
//                BEQ/BNE. A table of 2^IDX_BITS saturating two-bit counters
//                is indexed by PC[IDX_BITS+1:2]. The IF stage reads the
//                counter MSB combinationally; the ID stage compares the
//                forwarded operands, reports take_branch / mispredict, and
//                trains the counter on the clock edge that ends that cycle.
//  Config      : BP_STATS_EN - adds saturating 16-bit branch_count and
//                miss_count outputs (carried in the interface).
//  Ports       : clock - rising-edge clock
//                reset - synchronous active-high reset (counters -> 01)
//                bp    - branch_predictor_if.slave bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int IDX_BITS = 6,
   parameter int DATA_W   = 32
) (
   input  logic               clock,
   input  logic               reset,
   branch_predictor_if.slave  bp
);

   localparam int         TBL_DEPTH = 1 << IDX_BITS;
   localparam logic [5:0] C_OP_BEQ  = 6'b000100;
   localparam logic [5:0] C_OP_BNE  = 6'b000101;
   localparam logic [1:0] C_SEL_BAD = 2'b11;

   logic [1:0]          r_table [TBL_DEPTH];

   logic [DATA_W-1:0]   w_opa;
   logic [DATA_W-1:0]   w_opb;
   logic                w_ops_valid;
   logic                w_is_branch;
   logic                w_resolve;
   logic                w_equal;
   logic                w_taken;
   logic                w_mispredict;
   logic [IDX_BITS-1:0] w_if_idx;
   logic [IDX_BITS-1:0] w_id_idx;
   logic [1:0]          w_cur_ctr;
   logic [1:0]          w_next_ctr;

   // Only the index bits of the PCs matter; fold the rest away.
   logic                w_unused_pc;
   assign w_unused_pc = ^{bp.if_pc[DATA_W-1:IDX_BITS+2], bp.if_pc[1:0],
                          bp.id_pc[DATA_W-1:IDX_BITS+2], bp.id_pc[1:0]};

   // Forwarding muxes; select 11 falls to the register value but the
   // comparison result is suppressed by w_ops_valid.
   always_comb begin
      w_opa = bp.reg_out1;
      case (bp.fa)
         2'b01:   w_opa = bp.memwb_value;
         2'b10:   w_opa = bp.exmem_aluout;
         default: w_opa = bp.reg_out1;
      endcase
   end

   always_comb begin
      w_opb = bp.reg_out2;
      case (bp.fb)
         2'b01:   w_opb = bp.memwb_value;
         2'b10:   w_opb = bp.exmem_aluout;
         default: w_opb = bp.reg_out2;
      endcase
   end

   assign w_ops_valid  = (bp.fa != C_SEL_BAD) && (bp.fb != C_SEL_BAD);
   assign w_is_branch  = (bp.id_op == C_OP_BEQ) || (bp.id_op == C_OP_BNE);
   assign w_resolve    = bp.id_valid && !bp.id_stall && w_is_branch;
   assign w_equal      = (w_opa == w_opb);
   // A branch with invalid operands still resolves (as not taken) and trains.
   assign w_taken      = w_resolve && w_ops_valid &&
                         ((bp.id_op == C_OP_BEQ) ? w_equal : !w_equal);
   assign w_mispredict = w_resolve && (w_taken ^ bp.id_pred);

   assign bp.take_branch = w_taken;
   assign bp.mispredict  = w_mispredict;

   assign w_if_idx = bp.if_pc[IDX_BITS+1:2];
   assign w_id_idx = bp.id_pc[IDX_BITS+1:2];

   // Lookup reads the registered table directly, so a same-cycle update to
   // the same index is not visible until the following cycle.
   assign bp.pred_taken = r_table[w_if_idx][1];

   assign w_cur_ctr = r_table[w_id_idx];

   always_comb begin
      w_next_ctr = w_cur_ctr;
      if (w_taken) begin
         if (w_cur_ctr != 2'b11) begin
            w_next_ctr = w_cur_ctr + 2'b01;
         end
      end else begin
         if (w_cur_ctr != 2'b00) begin
            w_next_ctr = w_cur_ctr - 2'b01;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < TBL_DEPTH; i++) begin
            r_table[i] <= 2'b01;
         end
      end else if (w_resolve) begin
         r_table[w_id_idx] <= w_next_ctr;
      end
   end

`ifdef BP_STATS_EN
   logic [15:0] r_branch_count;
   logic [15:0] r_miss_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_branch_count <= 16'h0000;
         r_miss_count   <= 16'h0000;
      end else begin
         if (w_resolve && (r_branch_count != 16'hFFFF)) begin
            r_branch_count <= r_branch_count + 16'h0001;
         end
         if (w_mispredict && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'h0001;
         end
      end
   end

   assign bp.branch_count = r_branch_count;
   assign bp.miss_count   = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor. A reference model
//                of the counter table (integers 0..3 per entry) and of the
//                branch rules is checked against the DUT on every falling
//                edge, alongside directed vectors with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   localparam int         IDX_BITS = 6;
   localparam int         DATA_W   = 32;
   localparam int         DEPTH    = 1 << IDX_BITS;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   branch_predictor_if #(.DATA_W(DATA_W)) bp_if ();

   branch_predictor #(
      .IDX_BITS (IDX_BITS),
      .DATA_W   (DATA_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bp    (bp_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int mdl_ctr [DEPTH];
   bit mdl_valid = 1'b0;
   int mdl_br    = 0;
   int mdl_miss  = 0;

   function automatic int pc_index(input logic [31:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf);
      if (s == 2'd1) return bp_if.memwb_value;
      if (s == 2'd2) return bp_if.exmem_aluout;
      return rf;
   endfunction

   function automatic bit mdl_resolved();
      return bp_if.id_valid && !bp_if.id_stall &&
             (bp_if.id_op == OP_BEQ || bp_if.id_op == OP_BNE);
   endfunction

   function automatic bit mdl_take();
      logic [31:0] a;
      logic [31:0] b;
      if (!mdl_resolved()) return 1'b0;
      if (bp_if.fa == 2'd3 || bp_if.fb == 2'd3) return 1'b0;
      a = pick(bp_if.fa, bp_if.reg_out1);
      b = pick(bp_if.fb, bp_if.reg_out2);
      return (bp_if.id_op == OP_BEQ) ? (a == b) : (a != b);
   endfunction

   function automatic bit mdl_miss_now();
      return mdl_resolved() && (mdl_take() != bp_if.id_pred);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         foreach (mdl_ctr[i]) mdl_ctr[i] <= 1;
         mdl_br    <= 0;
         mdl_miss  <= 0;
         mdl_valid <= 1'b1;
      end else if (mdl_resolved()) begin
         if (mdl_take())
            mdl_ctr[pc_index(bp_if.id_pc)] <= (mdl_ctr[pc_index(bp_if.id_pc)] < 3) ?
                                              mdl_ctr[pc_index(bp_if.id_pc)] + 1 : 3;
         else
            mdl_ctr[pc_index(bp_if.id_pc)] <= (mdl_ctr[pc_index(bp_if.id_pc)] > 0) ?
                                              mdl_ctr[pc_index(bp_if.id_pc)] - 1 : 0;
         mdl_br <= (mdl_br < 65535) ? mdl_br + 1 : 65535;
         if (mdl_miss_now()) mdl_miss <= (mdl_miss < 65535) ? mdl_miss + 1 : 65535;
      end
   end

   always @(negedge clock) begin
      if (mdl_valid) begin
         check("model_pred_taken", bp_if.pred_taken, (mdl_ctr[pc_index(bp_if.if_pc)] >= 2));
         check("model_take_branch", bp_if.take_branch, mdl_take());
         check("model_mispredict", bp_if.mispredict, mdl_miss_now());
`ifdef BP_STATS_EN
         check("model_branch_count", bp_if.branch_count, mdl_br);
         check("model_miss_count", bp_if.miss_count, mdl_miss);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      bp_if.id_valid     = 1'b0;
      bp_if.id_stall     = 1'b0;
      bp_if.id_pc        = '0;
      bp_if.id_op        = 6'd0;
      bp_if.id_pred      = 1'b0;
      bp_if.fa           = 2'd0;
      bp_if.fb           = 2'd0;
      bp_if.reg_out1     = '0;
      bp_if.reg_out2     = '0;
      bp_if.memwb_value  = '0;
      bp_if.exmem_aluout = '0;
   endtask

   task automatic set_branch(input logic [31:0] pc, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic pred);
      bp_if.id_valid = 1'b1;
      bp_if.id_stall = 1'b0;
      bp_if.id_pc    = pc;
      bp_if.id_op    = op;
      bp_if.id_pred  = pred;
      bp_if.fa       = 2'd0;
      bp_if.fb       = 2'd0;
      bp_if.reg_out1 = a;
      bp_if.reg_out2 = b;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic pred);
      set_branch(pc, op, a, b, pred);
      next_cycle();
      idle();
   endtask

   // mixed vectors: pc, op, a, b, pred (aliasing pcs share index 1)
   logic [31:0] vec_pc [8] = '{32'hFFFF_FF04, 32'h0000_0104, 32'h0000_0008, 32'h1234_5678,
                               32'h0000_0004, 32'h0000_00FC, 32'h0000_0104, 32'h0000_0008};
   logic [5:0]  vec_op [8] = '{OP_BNE, OP_BEQ, OP_BNE, OP_BEQ, OP_BEQ, OP_BNE, 6'h23, OP_BEQ};
   logic [31:0] vec_a  [8] = '{32'h1, 32'hA5, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3, 32'h1, 32'h9};
   logic [31:0] vec_b  [8] = '{32'h2, 32'hA5, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h3, 32'h1, 32'h9};
   logic        vec_pr [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      reset = 1'b1;
      bp_if.if_pc = '0;
      idle();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state: every index weakly not taken
      bp_if.if_pc = 32'h40;
      @(negedge clock);
      check("reset_pred_0x40", bp_if.pred_taken, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         next_cycle();
         bp_if.if_pc = 32'(i * 4);
         @(negedge clock);
         check("reset_pred_idx", bp_if.pred_taken, 1'b0);
      end
      next_cycle();

      // First taken BEQ at 0x40 predicted not taken
      bp_if.if_pc = 32'h40;
      set_branch(32'h40, OP_BEQ, 32'd5, 32'd5, 1'b0);
      @(negedge clock);
      check("beq_take", bp_if.take_branch, 1'b1);
      check("beq_mispredict", bp_if.mispredict, 1'b1);
      next_cycle();
      idle();
      @(negedge clock);
      check("pred_after_train", bp_if.pred_taken, 1'b1);
      next_cycle();

      // Three more taken -> saturate at 11
      repeat (3) resolve(32'h40, OP_BEQ, 32'd9, 32'd9, 1'b1);
      // First not-taken: 11 -> 10, still predicts taken
      set_branch(32'h40, OP_BEQ, 32'd1, 32'd2, 1'b1);
      @(negedge clock);
      check("nt_take", bp_if.take_branch, 1'b0);
      check("nt_mispredict", bp_if.mispredict, 1'b1);
      next_cycle();
      idle();
      @(negedge clock);
      check("sat_high_hold", bp_if.pred_taken, 1'b1);
      next_cycle();
      repeat (3) resolve(32'h40, OP_BEQ, 32'd1, 32'd2, 1'b0);
      @(negedge clock);
      check("pred_after_4nt", bp_if.pred_taken, 1'b0);
      next_cycle();
      resolve(32'h40, OP_BEQ, 32'd1, 32'd2, 1'b0);   // stays 00
      resolve(32'h40, OP_BEQ, 32'd3, 32'd3, 1'b0);   // 00 -> 01
      @(negedge clock);
      check("sat_low_no_wrap", bp_if.pred_taken, 1'b0);
      next_cycle();
      resolve(32'h40, OP_BEQ, 32'd3, 32'd3, 1'b0);   // 01 -> 10

      // Forwarded operands
      set_branch(32'h80, OP_BNE, 32'd1, 32'd2, 1'b1);
      bp_if.fa = 2'd2; bp_if.exmem_aluout = 32'd7;
      bp_if.fb = 2'd1; bp_if.memwb_value  = 32'd7;
      @(negedge clock);
      check("bne_fwd_equal", bp_if.take_branch, 1'b0);
      check("bne_fwd_miss", bp_if.mispredict, 1'b1);
      next_cycle();
      set_branch(32'h80, OP_BEQ, 32'd1, 32'd2, 1'b0);
      bp_if.fa = 2'd1; bp_if.memwb_value  = 32'd3;
      bp_if.fb = 2'd2; bp_if.exmem_aluout = 32'd3;
      @(negedge clock);
      check("beq_fwd_equal", bp_if.take_branch, 1'b1);
      next_cycle();
      set_branch(32'h80, OP_BEQ, 32'd5, 32'd5, 1'b0);
      bp_if.fa = 2'd3; bp_if.memwb_value = 32'd5; bp_if.exmem_aluout = 32'd5;
      @(negedge clock);
      check("beq_invalid_sel", bp_if.take_branch, 1'b0);
      next_cycle();
      idle();

      // Stall at index 3 must neither resolve nor train
      set_branch(32'h0C, OP_BEQ, 32'd4, 32'd4, 1'b0);
      bp_if.id_stall = 1'b1;
      bp_if.if_pc = 32'h0C;
      @(negedge clock);
      check("stall_take", bp_if.take_branch, 1'b0);
      check("stall_miss", bp_if.mispredict, 1'b0);
      next_cycle();
      idle();
      @(negedge clock);
      check("stall_no_update", bp_if.pred_taken, 1'b0);
      next_cycle();
      resolve(32'h0C, OP_BEQ, 32'd4, 32'd4, 1'b0);   // 01 -> 10
      @(negedge clock);
      check("idx3_trained", bp_if.pred_taken, 1'b1);
      next_cycle();
      // Same-cycle update (10 -> 01) and lookup returns the old value
      set_branch(32'h0C, OP_BEQ, 32'd1, 32'd2, 1'b1);
      @(negedge clock);
      check("no_bypass_old", bp_if.pred_taken, 1'b1);
      next_cycle();
      idle();
      @(negedge clock);
      check("no_bypass_new", bp_if.pred_taken, 1'b0);
      next_cycle();

      // Non-branch opcode with equal operands must not train
      repeat (2) begin
         set_branch(32'h0C, 6'h23, 32'd4, 32'd4, 1'b1);
         next_cycle();
      end
      idle();
      @(negedge clock);
      check("nonbranch_no_update", bp_if.pred_taken, 1'b0);
      next_cycle();

      // Mixed vectors, checked by the model every cycle
      for (int i = 0; i < 8; i++) begin
         bp_if.if_pc = vec_pc[(i + 3) % 8];
         resolve(vec_pc[i], vec_op[i], vec_a[i], vec_b[i], vec_pr[i]);
      end

      // Reset wins over a simultaneous update (0x40 holds 10 here)
      bp_if.if_pc = 32'h40;
      set_branch(32'h40, OP_BEQ, 32'd6, 32'd6, 1'b1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      idle();
      @(negedge clock);
      check("reset_priority", bp_if.pred_taken, 1'b0);
      next_cycle();

`ifdef BP_STATS_EN
      // 10 resolves, 4 mispredicted
      for (int i = 0; i < 10; i++) begin
         resolve(32'(i * 4), OP_BEQ, 32'd8, 32'd8, (i < 4) ? 1'b0 : 1'b1);
      end
      @(negedge clock);
      check("stats_branch_10", bp_if.branch_count, 32'd10);
      check("stats_miss_4", bp_if.miss_count, 32'd4);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      check("stats_branch_clr", bp_if.branch_count, 32'd0);
      check("stats_miss_clr", bp_if.miss_count, 32'd0);
      next_cycle();
`endif

      repeat (2) next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
